// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if
//   Groups the stopwatch's button inputs and display-facing outputs.
//   master : drives the raw buttons, observes the count (board / testbench side)
//   slave  : the stopwatch itself
//   btn_start_stop, btn_clear : raw asynchronous push-buttons, active-high
//   digits   : packed BCD SS.hh, [15:12] tens of s ... [3:0] hundredths
//   running  : high while the stopwatch is counting
//   overflow : sticky, set when the count wraps 99.99 -> 00.00
interface bcd_stopwatch_if;
  logic        btn_start_stop;
  logic        btn_clear;
  logic [15:0] digits;
  logic        running;
  logic        overflow;

  modport master (
    output btn_start_stop, btn_clear,
    input  digits, running, overflow
  );

  modport slave (
    input  btn_start_stop, btn_clear,
    output digits, running, overflow
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
//   Four-digit BCD stopwatch (00.00 .. 99.99 s) for the seven-segment scan stage.
//   Two raw buttons (start/stop, clear) are synchronised and debounced here;
//   a prescaler derives the count tick from clk while running.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     sw    : bcd_stopwatch_if.slave (buttons in; digits/running/overflow out)
module bcd_stopwatch #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_stopwatch_if.slave sw
);

  localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam int DW        = $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // bit 0 = start/stop, bit 1 = clear
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {sw.btn_clear, sw.btn_start_stop};

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchroniser, then a counter that must see the
  // synced level disagree with the accepted level for DEB_CYCLES consecutive
  // cycles before the accepted level follows. The press pulse is registered in
  // the same edge that accepts a new high level, so it lasts exactly one cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [DW-1:0] cnt_q,   cnt_d;

    always_comb begin
      sync1_d = btn_raw[gi];
      sync2_d = sync1_q;
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          level_d = sync2_q;
          pulse_d = sync2_q;  // only a rising accepted level is a press
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[gi] = pulse_q;
  end

  // ---------------------------------------------------------------------------
  // Timebase and BCD counter
  // ---------------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [15:0] digits_q,   digits_d;
  logic        overflow_q, overflow_d;
  logic        running_q,  running_d;

  logic        tick;
  logic [4:0]  carry;
  logic [15:0] digits_inc;

  assign tick     = (state_q == RUN) && (presc_q == PW'(PRESC_MAX));
  assign carry[0] = tick;

  // Decimal ripple: each nibble advances only when every lower nibble is 9,
  // so a nibble can never leave 0..9.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] d;
    assign d                      = digits_q[4*gi +: 4];
    assign carry[gi+1]            = carry[gi] && (d == 4'd9);
    assign digits_inc[4*gi +: 4]  = !carry[gi]  ? d :
                                    (d == 4'd9) ? 4'd0 : d + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    digits_d   = digits_inc;
    overflow_d = overflow_q | carry[4];

    // Prescaler only advances while running, so PAUSE keeps the partial period.
    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    case (state_q)
      IDLE:    if (press[0]) state_d = RUN;
      RUN:     if (press[0]) state_d = PAUSE;
      PAUSE:   if (press[0]) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Clear overrides everything, including a tick or start/stop this cycle.
    if (press[1]) begin
      state_d    = IDLE;
      presc_d    = '0;
      digits_d   = '0;
      overflow_d = 1'b0;
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
    end
  end

  assign sw.digits   = digits_q;
  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
//   Directed sequence with randomised lengths, checked every cycle against a
//   reference model that tracks elapsed running cycles as a plain integer and
//   converts ticks to BCD arithmetically.
module tb_bcd_stopwatch;
  localparam int CLK_HZ  = 40;
  localparam int TICK_HZ = 10;
  localparam int DEB     = 4;
  localparam int P       = CLK_HZ / TICK_HZ;
  localparam int LAT     = DEB + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_stopwatch_if sw_if ();

  bcd_stopwatch #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: 0 = idle, 1 = run, 2 = pause
  int     m_state  = 0;
  longint m_cycles = 0;  // clock edges spent running since last clear/reset
  int     ss_cd    = 0;  // edges until a start/stop press takes effect
  int     clr_cd   = 0;  // edges until a clear press takes effect

  function automatic logic [15:0] to_bcd(input longint v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] m_digits();
    return to_bcd((m_cycles / P) % 10000);
  endfunction

  function automatic logic m_overflow();
    return (m_cycles / P) >= 10000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update model at the edge, compare at the following falling edge.
  task automatic step();
    bit fire_ss, fire_clr;
    @(posedge clk);
    fire_ss  = 1'b0;
    fire_clr = 1'b0;
    if (m_state == 1) m_cycles++;
    if (ss_cd > 0)  begin ss_cd--;  fire_ss  = (ss_cd == 0);  end
    if (clr_cd > 0) begin clr_cd--; fire_clr = (clr_cd == 0); end
    if (fire_clr) begin
      m_state  = 0;
      m_cycles = 0;
    end else if (fire_ss) begin
      m_state = (m_state == 1) ? 2 : 1;
    end
    @(negedge clk);
    check("cyc_digits",   32'(sw_if.digits),   32'(m_digits()));
    check("cyc_running",  32'(sw_if.running),  32'(m_state == 1));
    check("cyc_overflow", 32'(sw_if.overflow), 32'(m_overflow()));
  endtask

  task automatic raise(input bit ss, input bit clr);
    if (ss)  begin sw_if.btn_start_stop = 1'b1; ss_cd  = LAT; end
    if (clr) begin sw_if.btn_clear      = 1'b1; clr_cd = LAT; end
  endtask

  task automatic release_all();
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_clear      = 1'b0;
    repeat (DEB + 6) step();
  endtask

  task automatic press_ss();
    raise(1'b1, 1'b0);
    repeat (LAT) step();
    release_all();
  endtask

  task automatic run_until(input int ticks);
    longint n;
    n = longint'(ticks) * P - m_cycles;
    repeat (n) step();
  endtask

  initial begin
    int g, r, w, k, extra;
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_clear      = 1'b0;

    // Reset and idle stability
    repeat (3) step();
    rst_n = 1'b1;
    repeat (50) step();
    check("rst_digits",   32'(sw_if.digits),   32'h0000);
    check("rst_running",  32'(sw_if.running),  32'h0);
    check("rst_overflow", 32'(sw_if.overflow), 32'h0);

    // Short glitches are rejected: the plan's 3-cycle pulse, then a random one
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? DEB - 1 : int'($urandom_range(1, DEB - 1));
      sw_if.btn_start_stop = 1'b1;
      repeat (g) step();
      sw_if.btn_start_stop = 1'b0;
      repeat (10) step();
      check("glitch_running", 32'(sw_if.running), 32'h0);
    end

    // Held press: accepted exactly DEB+3 edges after first sampled high
    raise(1'b1, 1'b0);
    repeat (LAT - 1) step();
    check("lat_before", 32'(sw_if.running), 32'h0);
    step();
    check("lat_at", 32'(sw_if.running), 32'h1);
    release_all();

    // Pause at 00.42 with a partial prescaler period of r cycles
    r = int'($urandom_range(1, P - 1));
    repeat (42 * P + r - LAT - m_cycles) step();
    raise(1'b1, 1'b0);
    repeat (LAT) step();
    check("pause_digits", 32'(sw_if.digits), 32'h0042);
    release_all();
    w = int'($urandom_range(100, 500));
    repeat (w) step();
    check("pause_hold_digits",  32'(sw_if.digits),  32'h0042);
    check("pause_hold_running", 32'(sw_if.running), 32'h0);

    // Resume: first tick after the remaining P-r cycles
    raise(1'b1, 1'b0);
    repeat (LAT) step();
    k = 0;
    while (sw_if.digits == 16'h0042 && k < 2 * P) begin
      step();
      k++;
    end
    check("resume_first_tick", 32'(k), 32'(P - r));
    release_all();

    // Carry cascade
    run_until(99);
    check("carry_0099", 32'(sw_if.digits), 32'h0099);
    run_until(100);
    check("carry_0100", 32'(sw_if.digits), 32'h0100);
    run_until(123);
    check("count_0123", 32'(sw_if.digits), 32'h0123);
    run_until(999);
    check("carry_0999", 32'(sw_if.digits), 32'h0999);
    run_until(1000);
    check("carry_1000", 32'(sw_if.digits), 32'h1000);

    // Wrap
    run_until(9999);
    check("wrap_9999",     32'(sw_if.digits),   32'h9999);
    check("wrap_pre_ovf",  32'(sw_if.overflow), 32'h0);
    run_until(10000);
    check("wrap_0000",     32'(sw_if.digits),   32'h0000);
    check("wrap_ovf",      32'(sw_if.overflow), 32'h1);
    check("wrap_running",  32'(sw_if.running),  32'h1);
    extra = int'($urandom_range(1, 9));
    run_until(10000 + extra);
    check("post_wrap_digits", 32'(sw_if.digits),   32'(to_bcd(extra)));
    check("post_wrap_ovf",    32'(sw_if.overflow), 32'h1);

    // Clear and start/stop together: clear wins
    raise(1'b1, 1'b1);
    repeat (LAT) step();
    check("clr_digits",   32'(sw_if.digits),   32'h0000);
    check("clr_overflow", 32'(sw_if.overflow), 32'h0);
    check("clr_running",  32'(sw_if.running),  32'h0);
    release_all();

    // Restart, then asynchronous reset in the middle of a prescaler period
    press_ss();
    repeat (int'($urandom_range(3 * P, 12 * P))) step();
    k = 0;
    while (m_cycles % P != P / 2 && k < 2 * P) begin
      step();
      k++;
    end
    check("pre_async_running", 32'(sw_if.running), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_digits",   32'(sw_if.digits),   32'h0000);
    check("async_running",  32'(sw_if.running),  32'h0);
    check("async_overflow", 32'(sw_if.overflow), 32'h0);
    m_state  = 0;
    m_cycles = 0;
    ss_cd    = 0;
    clr_cd   = 0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("final_digits", 32'(sw_if.digits), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
